// File: rtl/muldiv_unit.sv
// Multiply / divide unit for the RISC-V M extension.
// One operation at a time. Division is restoring radix-2 on operand magnitudes.
// Multiplication is either single-cycle or iterative shift-add, chosen by FAST_MUL.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opb_q;     // multiplicand / divisor magnitude
  logic            neg_q;     // negate product or quotient at the end
  logic            rneg_q;    // negate remainder at the end
  logic [XLEN-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Operand decode on the request inputs
  // ---------------------------------------------------------------------------
  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, bypass;
  logic [XLEN-1:0]   a_mag, b_mag, bypass_res;
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;

  assign is_div   = op_i[2];
  // DIV/REM are signed (funct3[0]=0); MULH is s*s, MULHSU is s*u; MUL low bits are sign-agnostic.
  assign a_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
  assign b_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
  assign a_neg    = a_signed & a_i[XLEN-1];
  assign b_neg    = b_signed & b_i[XLEN-1];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign div_zero = (b_i == '0);
  assign div_ovf  = ~op_i[0] & (a_i == MIN_NEG) & (&b_i);
  assign a_ext    = {{XLEN{a_neg}}, a_i};
  assign b_ext    = {{XLEN{b_neg}}, b_i};
  assign fast_prod = a_ext * b_ext;
  // Operations that skip CALC and produce their result straight from the inputs.
  assign bypass   = is_div ? (div_zero | div_ovf) : (FAST_MUL != 0);

  // Result for the bypass paths: single-cycle multiply or division special cases.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bypass_res = '0;
    if (!is_div) begin
      bypass_res = (op_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end else if (div_zero) begin
      bypass_res = op_i[1] ? a_i : '1;
    end else begin
      bypass_res = op_i[1] ? '0 : a_i;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step for each algorithm
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   mul_acc_n, mul_lo_n, div_acc_n, div_lo_n, div_diff;
  logic              div_ge, last_calc;
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_acc_n = mul_sum[XLEN:1];
  assign mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};

  // Restoring division: shift in the next dividend bit, subtract when it fits.
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift[XLEN-1:0] - opb_q;
  assign div_acc_n = div_ge ? div_diff : div_shift[XLEN-1:0];
  assign div_lo_n  = {lo_q[XLEN-2:0], div_ge};

  assign last_calc = (cnt_q == CW'(1));
  assign prod_mag  = {mul_acc_n, mul_lo_n};
  assign prod_fix  = neg_q ? -prod_mag : prod_mag;
  assign quo_fix   = neg_q ? -div_lo_n : div_lo_n;
  assign rem_fix   = rneg_q ? -div_acc_n : div_acc_n;

  // Final result of an iterative operation, taken from the last step's values.
  always_comb begin
    calc_res = '0;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = bypass ? DONE : CALC;
        CALC:    if (last_calc) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter, datapath and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i && !flush_i) begin
        op_q   <= op_i;
        acc_q  <= '0;
        lo_q   <= a_mag;
        opb_q  <= b_mag;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt_q  <= CW'(XLEN);
        if (bypass) result_q <= bypass_res;
      end else if (state_q == CALC && !flush_i) begin
        acc_q <= op_q[2] ? div_acc_n : mul_acc_n;
        lo_q  <= op_q[2] ? div_lo_n  : mul_lo_n;
        cnt_q <= cnt_q - CW'(1);
        if (last_calc) result_q <= calc_res;
      end
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign stall_o  = (start_i && state_q == IDLE) || (state_q == CALC);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: one fast-multiply and one iterative-multiply
// instance, directed corner cases plus random operations against a reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_f = 1'b0, start_s = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;

  logic        busy_f, done_f, stall_f, busy_s, done_s, stall_s;
  logic [31:0] result_f, result_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_f = '0, last_s = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1)) u_fast (
    .clk(clk), .rst(rst), .start_i(start_f), .op_i(op), .a_i(a), .b_i(b), .flush_i(flush),
    .busy_o(busy_f), .done_o(done_f), .result_o(result_f), .stall_o(stall_f)
  );

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(0)) u_slow (
    .clk(clk), .rst(rst), .start_i(start_s), .op_i(op), .a_i(a), .b_i(b), .flush_i(flush),
    .busy_o(busy_s), .done_o(done_s), .result_o(result_s), .stall_o(stall_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, uy_s;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    uy_s = longint'(uy);
    p = '0;
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy_s; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input bit slow, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return slow ? XLEN + 1 : 1;
    if (y == 0) return 1;
    if (!f[0] && x == MIN_NEG && y == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one operation and check latency, stall profile, result and return to IDLE.
  // poke_at > 0 pulses start_i with other operands at that cycle of the operation.
  task automatic do_op(input bit slow, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input int poke_at, input string tag);
    logic [31:0] exp;
    int          lat, stalls, exp_lat;
    bit          seen;
    exp     = ref_result(f, x, y);
    exp_lat = ref_latency(slow, f, x, y);
    @(negedge clk);
    op = f; a = x; b = y;
    if (slow) start_s = 1'b1; else start_f = 1'b1;
    #1 check($sformatf("%s_stall_req", tag), slow ? stall_s : stall_f, 1);
    @(negedge clk);
    start_f = 1'b0; start_s = 1'b0;
    lat = 0; stalls = 0; seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      if (slow ? done_s : done_f) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (slow ? stall_s : stall_f) stalls++;
        if (c == poke_at) begin
          op = 3'd5; a = 32'd50; b = 32'd1;
          if (slow) start_s = 1'b1; else start_f = 1'b1;
        end
        @(negedge clk);
        start_f = 1'b0; start_s = 1'b0;
      end
    end
    check($sformatf("%s_latency", tag), lat, exp_lat);
    if (seen) begin
      check($sformatf("%s_result", tag), slow ? result_s : result_f, exp);
      check($sformatf("%s_stall_cycles", tag), stalls, exp_lat - 1);
      check($sformatf("%s_stall_done", tag), slow ? stall_s : stall_f, 0);
      check($sformatf("%s_busy_done", tag), slow ? busy_s : busy_f, 1);
      @(negedge clk);
      check($sformatf("%s_done_pulse", tag), slow ? done_s : done_f, 0);
      check($sformatf("%s_idle_after", tag), slow ? busy_s : busy_f, 0);
      check($sformatf("%s_result_hold", tag), slow ? result_s : result_f, exp);
      if (slow) last_s = exp; else last_f = exp;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_busy_f", tag), busy_f, 0);
    check($sformatf("%s_done_f", tag), done_f, 0);
    check($sformatf("%s_stall_f", tag), stall_f, 0);
    check($sformatf("%s_result_f", tag), result_f, 0);
    check($sformatf("%s_busy_s", tag), busy_s, 0);
    check($sformatf("%s_result_s", tag), result_s, 0);
  endtask

  initial begin
    int          dones;
    logic [2:0]  rf;
    logic [31:0] rx, ry;

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Unsigned division and remainder, with a start poked mid-CALC that must be ignored
    do_op(1'b0, 3'd5, 32'd100, 32'd7, 5, "divu_100_7");
    do_op(1'b0, 3'd7, 32'd100, 32'd7, 0, "remu_100_7");

    // Signed division
    do_op(1'b0, 3'd4, -32'sd7, 32'd2, 0, "div_m7_2");
    do_op(1'b0, 3'd6, -32'sd7, 32'd2, 0, "rem_m7_2");

    // Special cases
    do_op(1'b0, 3'd5, 32'd5, 32'd0, 0, "divu_by0");
    do_op(1'b0, 3'd7, 32'd5, 32'd0, 0, "remu_by0");
    do_op(1'b0, 3'd4, MIN_NEG, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(1'b0, 3'd6, MIN_NEG, 32'hFFFF_FFFF, 0, "rem_ovf");

    // Multiplies, single-cycle and iterative
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 3'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, $sformatf("fmul_op%0d", i));
      do_op(1'b1, 3'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, $sformatf("smul_op%0d", i));
    end

    // Flush on the 10th CALC cycle of DIVU
    do_op(1'b0, 3'd5, 32'd100, 32'd7, 0, "pre_flush");
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd3; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", busy_f, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", busy_f, 0);
    check("flush_done", done_f, 0);
    check("flush_result_hold", result_f, last_f);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_f) dones++;
    end
    check("flush_no_done", dones, 0);

    // Flush wins over start in IDLE
    @(negedge clk);
    op = 3'd5; a = 32'd8; b = 32'd2; start_f = 1'b1; flush = 1'b1;
    @(negedge clk);
    start_f = 1'b0; flush = 1'b0;
    check("flush_vs_start_idle", busy_f, 0);
    check("flush_vs_start_result", result_f, last_f);

    // Flush in DONE: the pulse is still visible, unit returns to IDLE
    @(negedge clk);
    op = 3'd0; a = 32'd6; b = 32'd7; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    flush = 1'b1;
    #1 check("flush_in_done_pulse", done_f, 1);
    check("flush_in_done_result", result_f, 32'd42);
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_done_idle", busy_f, 0);
    last_f = 32'd42;

    // Reset mid-CALC
    @(negedge clk);
    op = 3'd5; a = 32'd77; b = 32'd5; start_f = 1'b1; start_s = 1'b1;
    @(negedge clk);
    start_f = 1'b0; start_s = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_calc_busy", busy_f, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_all_zero("reset_mid_calc");
    do_op(1'b0, 3'd5, 32'd9, 32'd3, 0, "divu_9_3");

    // Random operations
    for (int i = 0; i < 48; i++) begin
      rf = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 9))
        0:       ry = 32'd0;
        1:       begin rx = MIN_NEG; ry = 32'hFFFF_FFFF; end
        2:       ry = $urandom_range(1, 15);
        3:       rx = $urandom_range(0, 255);
        default: ;
      endcase
      do_op(i % 3 == 0, rf, rx, ry, 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width in bits; legal values 8..64, even.
REQ-002 SHALL have parameter FAST_MUL, default 1: 1 selects a single-cycle multiplier, 0 selects an iterative shift-add multiplier.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: request a new operation.
REQ-006 SHALL have port op_i, input, 3 bits: operation select, equal to the M-extension funct3.
REQ-007 SHALL have port a_i, input, XLEN bits: operand rs1.
REQ-008 SHALL have port b_i, input, XLEN bits: operand rs2.
REQ-009 SHALL have port flush_i, input, 1 bit: abort the operation in flight.
REQ-010 SHALL have port busy_o, output, 1 bit: unit is not IDLE.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse; result_o is valid.
REQ-012 SHALL have port result_o, output, XLEN bits: operation result.
REQ-013 SHALL have port stall_o, output, 1 bit: pipeline freeze request.

Function
REQ-014 SHALL decode op_i as: 000 MUL (low XLEN bits), 001 MULH (signed x signed), 010 MULHSU (signed x unsigned), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; MULH* return the high XLEN bits of the 2*XLEN-bit product.
REQ-015 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-016 SHALL capture a_i, b_i and op_i, and leave IDLE, only when start_i=1 in IDLE; start_i is ignored in every other state.
REQ-017 SHALL, for division, use restoring radix-2 on operand magnitudes: CALC lasts exactly XLEN cycles, counted by a down-counter of width clog2(XLEN)+1, followed by DONE; start edge to done_o = XLEN+1 cycles.
REQ-018 SHALL give the quotient the sign of a XOR b and the remainder the sign of a (truncating division).
REQ-019 SHALL, on divide by zero, bypass CALC and go to DONE on the next edge: quotient all ones, remainder = a.
REQ-020 SHALL, on signed overflow (DIV/REM with a = most-negative and b = all ones), bypass CALC: quotient = a, remainder = 0.
REQ-021 SHALL, when FAST_MUL=1, take multiply ops from IDLE directly to DONE (latency 1).
REQ-022 SHALL, when FAST_MUL=0, run multiply ops through XLEN CALC cycles (latency XLEN+1).
REQ-023 SHALL assert done_o for exactly one cycle, in DONE, and then return to IDLE.
REQ-024 SHALL update result_o only on entry to DONE and hold it until the next DONE.
REQ-025 SHALL drive stall_o combinationally as (start_i AND IDLE) OR CALC, and deassert it in DONE so the requesting instruction advances with its result.
REQ-026 SHALL drive busy_o = 1 in CALC and DONE.
REQ-027 SHALL, on flush_i=1 in any state, enter IDLE on the next edge with no done_o pulse; result_o is unchanged.
REQ-028 SHALL let flush_i win over start_i when both are asserted in IDLE.
REQ-029 SHALL let a flush in DONE suppress nothing already asserted in that cycle; the unit still returns to IDLE.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, force state IDLE, counter 0, result_o 0, done_o 0 and all operand registers 0.
REQ-031 SHALL make busy_o and stall_o 0 in the cycle after reset, including when reset is applied mid-CALC.
REQ-032 SHALL give rst priority over flush_i and start_i.

Verification (XLEN=32, FAST_MUL=1 unless noted)
REQ-033 SHALL cover DIVU 100/7: done_o 33 cycles after start with result_o=14; REMU on the same operands gives 2; stall_o is high for 32 cycles.
REQ-034 SHALL cover signed division: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF.
REQ-035 SHALL cover the special cases: DIVU 5/0 gives 0xFFFFFFFF with done_o 1 cycle after start; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM on the same operands gives 0.
REQ-036 SHALL cover multiply with a = b = 0xFFFFFFFF: MUL gives 1, MULH gives 0, MULHU gives 0xFFFFFFFE, MULHSU gives 0xFFFFFFFF; repeat with FAST_MUL=0 and check latency 33.
REQ-037 SHALL cover flush_i at the 10th CALC cycle of DIVU: IDLE next cycle, no done_o, result_o holds its previous value; a start_i issued during CALC is ignored.
REQ-038 SHALL cover rst=0 mid-CALC: all outputs 0 next cycle; a following DIVU 9/3 returns 3.
